// File: rtl/three_stage_tx_pkg.sv
// Shared constants for the three-slot toggle-strobe link: flit geometry,
// FSM encodings and the receiver slot ring.
package three_stage_tx_pkg;

   localparam int CDATASIZE = 16;
   localparam int TAIL_BIT  = CDATASIZE - 1;

   localparam logic [1:0] SLOT_LAST = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2,
      ST_END    = 2'd3
   } tx_state_e;

   // Receiver slot ring 0->1->2->0; code 3 never appears.
   function automatic logic [1:0] slot_next(input logic [1:0] slot);
      return (slot == SLOT_LAST) ? 2'd0 : slot + 2'd1;
   endfunction

endpackage

// File: rtl/three_stage_tx_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/three_stage_tx.sv
// Transmit end of the three-slot toggle-strobe link.
//   state  | meaning
//   IDLE   | between packets, State_r2p low, ready for a head flit
//   ACTIVE | packet open, ready for the next flit
//   GAP    | forced idle cycles between flits of one packet
//   END    | tail launched, State_r2p held low before next head
module three_stage_tx
   import three_stage_tx_pkg::*;
#(
   parameter int MIN_GAP = 0,
   parameter int PKT_GAP = 1,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CDATASIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [CDATASIZE-1:0] CData_r2p,
   output logic                 Strobe_r2p,
   output logic                 State_r2p,
   output logic                 Clock_r2p,
   input  logic                 Feedback_p2r,
   output logic [1:0]           tx_slot,
   output logic [CNT_W-1:0]     flit_cnt,
   output logic                 busy
);

   localparam int TMR_W = 8;
   localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
   localparam logic [TMR_W-1:0] END_LOAD = TMR_W'((PKT_GAP > 0) ? PKT_GAP - 1 : 0);

   tx_state_e              state_q, state_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic [CDATASIZE-1:0]   cdata_q, cdata_d;
   logic                   strobe_q, strobe_d;
   logic                   link_st_q, link_st_d;
   logic [1:0]             slot_q, slot_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stall;
   logic                   accept;

   sync_2ff u_fb_sync (
      .clk (clk),
      .rst (rst),
      .d   (Feedback_p2r),
      .q   (stall)
   );

   // rst gating keeps in_ready low for the whole reset pulse.
   assign in_ready = !rst && !stall && (state_q == ST_IDLE || state_q == ST_ACTIVE);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         cdata_q   <= '0;
         strobe_q  <= 1'b0;
         link_st_q <= 1'b0;
         slot_q    <= 2'd0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         cdata_q   <= cdata_d;
         strobe_q  <= strobe_d;
         link_st_q <= link_st_d;
         slot_q    <= slot_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         ST_IDLE, ST_ACTIVE: begin
            if (accept) begin
               if (in_data[TAIL_BIT]) begin
                  state_d = ST_END;
                  tmr_d   = END_LOAD;
               end else if (MIN_GAP > 0) begin
                  state_d = ST_GAP;
                  tmr_d   = GAP_LOAD;
               end else begin
                  state_d = ST_ACTIVE;
               end
            end
         end
         ST_GAP: begin
            if (tmr_q == '0) state_d = ST_ACTIVE;
            else             tmr_d   = tmr_q - 1'b1;
         end
         ST_END: begin
            if (tmr_q == '0) state_d = ST_IDLE;
            else             tmr_d   = tmr_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cdata_d   = cdata_q;
      strobe_d  = strobe_q;
      link_st_d = link_st_q;
      slot_d    = slot_q;
      cnt_d     = cnt_q;
      if (accept) begin
         cdata_d   = in_data;
         strobe_d  = ~strobe_q;
         link_st_d = 1'b1;
         slot_d    = slot_next(slot_q);
         cnt_d     = cnt_q + CNT_W'(1);
      end else if (state_q == ST_END) begin
         link_st_d = 1'b0;
      end
   end

   assign CData_r2p  = cdata_q;
   assign Strobe_r2p = strobe_q;
   assign State_r2p  = link_st_q;
   assign Clock_r2p  = ~clk;
   assign tx_slot    = slot_q;
   assign flit_cnt   = cnt_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_three_stage_tx.sv
// Bench for three_stage_tx: two instances (back-to-back and gapped/narrow
// counter) share stimulus and are checked every cycle against a launch-timing model.
module tb_three_stage_tx;
   import three_stage_tx_pkg::*;

   localparam int N = 2;

   function automatic int mg(input int i); return (i == 0) ? 0 : 2; endfunction
   function automatic int pg(input int i); return (i == 0) ? 1 : 2; endfunction
   function automatic int cw(input int i); return (i == 0) ? 16 : 3; endfunction

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [CDATASIZE-1:0] in_data = '0;
   logic                 in_valid = 1'b0;
   logic                 fb = 1'b0;

   logic                 a_rdy, a_stb, a_st, a_clk, a_busy;
   logic [CDATASIZE-1:0] a_cd;
   logic [1:0]           a_slot;
   logic [15:0]          a_cnt;
   logic                 b_rdy, b_stb, b_st, b_clk, b_busy;
   logic [CDATASIZE-1:0] b_cd;
   logic [1:0]           b_slot;
   logic [2:0]           b_cnt;

   three_stage_tx #(.MIN_GAP(0), .PKT_GAP(1), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_rdy),
      .CData_r2p(a_cd), .Strobe_r2p(a_stb), .State_r2p(a_st), .Clock_r2p(a_clk),
      .Feedback_p2r(fb), .tx_slot(a_slot), .flit_cnt(a_cnt), .busy(a_busy));

   three_stage_tx #(.MIN_GAP(2), .PKT_GAP(2), .CNT_W(3)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_rdy),
      .CData_r2p(b_cd), .Strobe_r2p(b_stb), .State_r2p(b_st), .Clock_r2p(b_clk),
      .Feedback_p2r(fb), .tx_slot(b_slot), .flit_cnt(b_cnt), .busy(b_busy));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: each instance may accept at edge number >= nxt, and
   // only when feedback seen two edges earlier was low.
   int                   e_n = 0;
   bit                   fb_hist[$];
   int                   nxt[N];
   int                   tail_e[N];
   bit                   tseen[N];
   bit                   open_pkt[N];
   bit                   m_st[N];
   bit                   m_stb[N];
   logic [CDATASIZE-1:0] m_cd[N];
   int                   m_slot[N];
   int unsigned          m_cnt[N];

   function automatic bit m_stall();
      return (fb_hist.size() >= 2) ? fb_hist[fb_hist.size() - 2] : 1'b0;
   endfunction

   function automatic bit m_ready(input int i);
      return !rst && (e_n + 1 >= nxt[i]) && !m_stall();
   endfunction

   task automatic model_reset();
      fb_hist.delete();
      for (int i = 0; i < N; i++) begin
         nxt[i] = 0; tail_e[i] = 0; tseen[i] = 0; open_pkt[i] = 0;
         m_st[i] = 0; m_stb[i] = 0; m_cd[i] = '0; m_slot[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic model_edge();
      int E;
      bit acc;
      bit tail;
      E = e_n + 1;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            acc  = in_valid && m_ready(i);
            tail = in_data[TAIL_BIT];
            if (acc) begin
               m_cd[i]   = in_data;
               m_stb[i]  = !m_stb[i];
               m_st[i]   = 1;
               m_slot[i] = (m_slot[i] + 1) % 3;
               m_cnt[i]  = (m_cnt[i] + 1) % (1 << cw(i));
               nxt[i]    = E + 1 + (tail ? pg(i) : mg(i));
               open_pkt[i] = !tail;
               if (tail) begin
                  tseen[i]  = 1;
                  tail_e[i] = E;
               end
            end else if (tseen[i] && E == tail_e[i] + 1) begin
               m_st[i] = 0;
            end
         end
         fb_hist.push_back(fb);
         if (fb_hist.size() > 2) void'(fb_hist.pop_front());
      end
      e_n = E;
   endtask

   task automatic check_ready(input int i);
      check_val($sformatf("d%0d in_ready", i), {31'd0, (i == 0) ? a_rdy : b_rdy}, {31'd0, m_ready(i)});
   endtask

   task automatic check_outs(input int i);
      logic [CDATASIZE-1:0] g_cd;
      logic                 g_stb, g_st, g_clk, g_busy;
      logic [1:0]           g_slot;
      logic [15:0]          g_cnt;
      bit                   e_busy;
      if (i == 0) begin
         g_cd = a_cd; g_stb = a_stb; g_st = a_st; g_clk = a_clk; g_busy = a_busy;
         g_slot = a_slot; g_cnt = a_cnt;
      end else begin
         g_cd = b_cd; g_stb = b_stb; g_st = b_st; g_clk = b_clk; g_busy = b_busy;
         g_slot = b_slot; g_cnt = {13'd0, b_cnt};
      end
      e_busy = open_pkt[i] || (tseen[i] && e_n < tail_e[i] + pg(i));
      check_val($sformatf("d%0d CData", i),  {16'd0, g_cd},   {16'd0, m_cd[i]});
      check_val($sformatf("d%0d Strobe", i), {31'd0, g_stb},  {31'd0, m_stb[i]});
      check_val($sformatf("d%0d State", i),  {31'd0, g_st},   {31'd0, m_st[i]});
      check_val($sformatf("d%0d tx_slot", i), {30'd0, g_slot}, m_slot[i]);
      check_val($sformatf("d%0d flit_cnt", i), {16'd0, g_cnt}, m_cnt[i]);
      check_val($sformatf("d%0d busy", i),   {31'd0, g_busy}, {31'd0, e_busy});
      check_val($sformatf("d%0d Clock", i),  {31'd0, g_clk},  {31'd0, ~clk});
   endtask

   task automatic step(input bit r, input bit v, input logic [CDATASIZE-1:0] d, input bit f);
      @(negedge clk);
      if (r && !rst) model_reset();
      rst = r; in_valid = v; in_data = d; fb = f;
      #1;
      for (int i = 0; i < N; i++) check_ready(i);
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < N; i++) check_outs(i);
   endtask

   // Reset raised between edges; outputs must clear without waiting for a clock.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < N; i++) begin
         check_ready(i);
         check_outs(i);
      end
      step(1, 0, '0, 0);
      step(1, 0, '0, 0);
      step(0, 0, '0, 0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, '0, 0);
   endtask

   initial begin
      logic [CDATASIZE-1:0] d;
      model_reset();
      for (int k = 0; k < 3; k++) step(1, 0, '0, 0);
      step(0, 0, '0, 0);

      // 3-flit packet back-to-back
      step(0, 1, 16'h0A01, 0);
      step(0, 1, 16'h0A02, 0);
      step(0, 1, 16'h8A03, 0);
      idle(1);
      check_val("t2 d0 flit_cnt", {16'd0, a_cnt}, 32'd3);
      check_val("t2 d0 tx_slot", {30'd0, a_slot}, 32'd0);
      idle(6);

      // feedback raised mid-packet, tail offered during and after the stall
      step(0, 1, 16'h0B01, 0);
      step(0, 1, 16'h0B02, 0);
      for (int k = 0; k < 3; k++) step(0, 0, '0, 1);
      for (int k = 0; k < 4; k++) step(0, 1, 16'h8B03, 1);
      for (int k = 0; k < 4; k++) step(0, 1, 16'h8B03, 0);
      idle(6);

      // 4-flit packet, then a single-flit head right behind the tail
      step(0, 1, 16'h0C01, 0);
      step(0, 1, 16'h0C02, 0);
      step(0, 1, 16'h0C03, 0);
      step(0, 1, 16'h8C04, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 16'h8D01, 0);
      idle(6);

      // async reset after flit 2 of 3, then a fresh packet
      step(0, 1, 16'h0E01, 0);
      step(0, 1, 16'h0E02, 0);
      async_reset();
      step(0, 1, 16'h0F01, 0);
      check_val("t6 d0 Strobe", {31'd0, a_stb}, 32'd1);
      check_val("t6 d0 tx_slot", {30'd0, a_slot}, 32'd1);
      check_val("t6 d0 flit_cnt", {16'd0, a_cnt}, 32'd1);
      step(0, 0, '0, 0);
      step(0, 1, 16'h8F02, 0);
      idle(8);

      // randomized traffic with feedback bursts and occasional resets
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 599) == 0) begin
            async_reset();
         end else begin
            d = CDATASIZE'($urandom);
            d[TAIL_BIT] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) fb = !fb;
            step(0, ($urandom_range(0, 3) != 0), d, fb);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
